// File: rtl/dec3x8_seq.sv
// Sequenced 3-to-8 decoder: buffers 3-bit codes in a small FIFO and plays each one
// out as a registered one-hot strobe of PULSE_LEN cycles followed by GAP idle cycles.
module dec3x8_seq #(
  parameter int PULSE_LEN  = 4,
  parameter int GAP        = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       en,
  output logic [7:0] o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] level_o
);

  localparam int          AW           = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;
  localparam logic [2:0]  DEPTH        = 3'(FIFO_DEPTH);
  localparam logic [7:0]  PULSE_RELOAD = 8'(PULSE_LEN - 1);
  localparam logic [7:0]  GAP_RELOAD   = 8'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [2:0]    count_q, count_d;
  logic          push, pop, empty, loadOk;
  logic [7:0]    strobe;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    o_q, o_d;
  logic          done_q, done_d;

  assign empty   = (count_q == 3'd0);
  assign ready_o = (count_q != DEPTH);
  assign push    = valid_i && ready_o;
  assign loadOk  = !empty && en;
  assign strobe  = 8'd1 << mem_q[rdPtr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 3'd1;
    else if (!push && pop)
      count_d = count_q - 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (pop)  rdPtr_q <= rdPtr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= code_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (loadOk) begin
          pop     = 1'b1;
          o_d     = strobe;
          cnt_d   = PULSE_RELOAD;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          o_d    = 8'd0;
          done_d = 1'b1;
          if (GAP > 0) begin
            cnt_d   = GAP_RELOAD;
            state_d = S_GAP;
          end else if (loadOk) begin
            // Back-to-back reload replaces the old bit outright, so o never goes multi-hot.
            pop   = 1'b1;
            o_d   = strobe;
            cnt_d = PULSE_RELOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (loadOk) begin
          pop     = 1'b1;
          o_d     = strobe;
          cnt_d   = PULSE_RELOAD;
          state_d = S_DRIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      o_q     <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      done_q  <= done_d;
    end
  end

  assign o       = o_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != S_IDLE);
  assign level_o = count_q;

endmodule

// File: tb/tb_dec3x8_seq.sv
// Directed bench for dec3x8_seq: instance A uses default timing, instance B runs
// PULSE_LEN=1/GAP=0 for back-to-back streaming.
module tb_dec3x8_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] codeA, codeB;
  logic       validA, validB, enA, enB;
  logic       readyA, readyB, busyA, busyB, doneA, doneB;
  logic [7:0] oA, oB;
  logic [2:0] levelA, levelB;

  int testCount = 0;
  int failCount = 0;
  int hotErrs   = 0;
  int doneErrs  = 0;
  int qA[$];
  int qB[$];
  logic [7:0] prevOA = 8'd0;
  logic       prevDoneA = 1'b0;
  int exp2[4] = '{0, 7, 3, 6};
  int exp4[2] = '{2, 6};
  logic [2:0] codes6[20];

  always #5 clk = ~clk;

  dec3x8_seq #(.PULSE_LEN(4), .GAP(1), .FIFO_DEPTH(2)) dutA (
    .clk(clk), .rst_n(rst_n), .code_i(codeA), .valid_i(validA), .ready_o(readyA),
    .en(enA), .o(oA), .busy_o(busyA), .done_o(doneA), .level_o(levelA)
  );

  dec3x8_seq #(.PULSE_LEN(1), .GAP(0), .FIFO_DEPTH(2)) dutB (
    .clk(clk), .rst_n(rst_n), .code_i(codeB), .valid_i(validB), .ready_o(readyB),
    .en(enB), .o(oB), .busy_o(busyB), .done_o(doneB), .level_o(levelB)
  );

  function automatic int bitIndex(input logic [7:0] v);
    int idx = -1;
    for (int i = 0; i < 8; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  // Records strobe order for both instances and flags multi-hot or doubled done pulses.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (!$onehot0(oA) || !$onehot0(oB)) hotErrs++;
      if (oA != 8'd0 && prevOA == 8'd0) qA.push_back(bitIndex(oA));
      if (oB != 8'd0) qB.push_back(bitIndex(oB));
      if (doneA && prevDoneA) doneErrs++;
    end
    prevOA    = oA;
    prevDoneA = doneA;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit toB, input logic [2:0] c);
    bit acc;
    int n = 0;
    if (toB) begin validB = 1'b1; codeB = c; end
    else     begin validA = 1'b1; codeA = c; end
    do begin
      acc = toB ? readyB : readyA;
      tick();
      n++;
    end while (!acc && n < 200);
    if (toB) validB = 1'b0;
    else     validA = 1'b0;
    checkOutput("push timeout", {31'd0, !acc}, 32'd0);
  endtask

  task automatic waitIdleA();
    int n = 0;
    while ((busyA || levelA != 3'd0) && n < 200) begin
      tick();
      n++;
    end
    checkOutput("idleA timeout", {31'd0, n >= 200}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    codeA = 3'd0; codeB = 3'd0;
    validA = 1'b0; validB = 1'b0;
    enA = 1'b1; enB = 1'b1;

    // Test 1: reset state, then a single code 5.
    #12;
    checkOutput("rst o", oA, 8'h00);
    checkOutput("rst ready", readyA, 1);
    checkOutput("rst level", levelA, 0);
    checkOutput("rst busy", busyA, 0);
    checkOutput("rst done", doneA, 0);
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b0, 3'd5);
    checkOutput("t1 level after push", levelA, 1);
    checkOutput("t1 no bypass", oA, 8'h00);
    tick();
    checkOutput("t1 o first", oA, 8'h20);
    checkOutput("t1 busy", busyA, 1);
    checkOutput("t1 level popped", levelA, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t1 o held", oA, 8'h20);
      checkOutput("t1 done low", doneA, 0);
    end
    tick();
    checkOutput("t1 o end", oA, 8'h00);
    checkOutput("t1 done", doneA, 1);
    tick();
    checkOutput("t1 done pulse", doneA, 0);
    checkOutput("t1 busy end", busyA, 0);

    // Test 2: 0,7,3 fill the FIFO; a fourth code is held off until space frees.
    qA.delete();
    applyStimulus(1'b0, 3'd0);
    applyStimulus(1'b0, 3'd7);
    applyStimulus(1'b0, 3'd3);
    checkOutput("t2 ready full", readyA, 0);
    checkOutput("t2 level full", levelA, 2);
    checkOutput("t2 o first", oA, 8'h01);
    applyStimulus(1'b0, 3'd6);
    waitIdleA();
    checkOutput("t2 count", qA.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t2 code%0d", i), (i < qA.size()) ? qA[i] : -1, exp2[i]);

    // Test 4: en low holds off strobes with codes buffered.
    qA.delete();
    enA = 1'b0;
    applyStimulus(1'b0, 3'd2);
    applyStimulus(1'b0, 3'd6);
    tick(); tick(); tick();
    checkOutput("t4 o held off", oA, 8'h00);
    checkOutput("t4 level", levelA, 2);
    checkOutput("t4 ready", readyA, 0);
    checkOutput("t4 busy", busyA, 0);
    enA = 1'b1;
    tick();
    checkOutput("t4 first strobe", oA, 8'h04);
    waitIdleA();
    checkOutput("t4 count", qA.size(), 2);
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("t4 code%0d", i), (i < qA.size()) ? qA[i] : -1, exp4[i]);

    // Test 5: async reset mid-strobe with one code still buffered.
    qA.delete();
    applyStimulus(1'b0, 3'd1);
    applyStimulus(1'b0, 3'd4);
    checkOutput("t5 o driving", oA, 8'h02);
    checkOutput("t5 level", levelA, 1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t5 async o", oA, 8'h00);
    checkOutput("t5 async level", levelA, 0);
    checkOutput("t5 async ready", readyA, 1);
    checkOutput("t5 async busy", busyA, 0);
    #3 rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (oA != 8'd0) seen++;
      end
      checkOutput("t5 no strobe after reset", seen, 0);
    end
    checkOutput("t5 strobes", qA.size(), 1);

    // Test 3: PULSE_LEN=1, GAP=0 stream 1,2,4.
    applyStimulus(1'b1, 3'd1);
    checkOutput("t3 o e0", oB, 8'h00);
    applyStimulus(1'b1, 3'd2);
    checkOutput("t3 o e1", oB, 8'h02);
    checkOutput("t3 done e1", doneB, 0);
    applyStimulus(1'b1, 3'd4);
    checkOutput("t3 o e2", oB, 8'h04);
    checkOutput("t3 done e2", doneB, 1);
    tick();
    checkOutput("t3 o e3", oB, 8'h10);
    checkOutput("t3 done e3", doneB, 1);
    tick();
    checkOutput("t3 o e4", oB, 8'h00);
    checkOutput("t3 done e4", doneB, 1);
    checkOutput("t3 busy e4", busyB, 0);
    tick();
    checkOutput("t3 done e5", doneB, 0);

    // Test 6: streaming push/pop at level 1 keeps order.
    qB.delete();
    for (int i = 0; i < 20; i++) codes6[i] = 3'($urandom_range(0, 7));
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, codes6[i]);
      checkOutput($sformatf("t6 level%0d", i), levelB, 1);
    end
    tick(); tick();
    checkOutput("t6 count", qB.size(), 20);
    for (int i = 0; i < 20; i++)
      checkOutput($sformatf("t6 code%0d", i), (i < qB.size()) ? qB[i] : -1, {29'd0, codes6[i]});

    checkOutput("multi-hot cycles", hotErrs, 0);
    checkOutput("done back-to-back A", doneErrs, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
